// File: rtl/triumph_if_fetch.sv
// triumph_if_fetch: instruction fetch stage with a 2-deep prefetch FIFO, in-order responses and branch redirect
module triumph_if_fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] rsp_pc;
    logic [31:0] target;
    logic [31:0] fifo_pc [2];
    logic [31:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic        stale;
    logic [1:0]  count;
    logic [1:0]  outstanding;
    logic [1:0]  discard;
    logic        granted;
    logic        rsp_ok;
    logic        drop;
    logic        push;
    logic        pop;
    logic        issue;
    logic [1:0]  count_n;
    logic [1:0]  out_n;
    logic [1:0]  discard_n;
    logic [31:0] pc_n;

    // next-cycle bookkeeping; a grant on a request left pending across a redirect is counted for discard and does not advance pc
    always_comb begin
        target    = branch_target_i & 32'hFFFF_FFFC;
        granted   = instr_req_o & instr_gnt_i;
        rsp_ok    = instr_rvalid_i & (outstanding != 2'd0);
        drop      = rsp_ok & (discard != 2'd0);
        push      = rsp_ok & ~drop & ~branch_i;
        pop       = instr_valid_o & instr_ready_i;
        out_n     = outstanding + {1'b0, granted} - {1'b0, rsp_ok};
        count_n   = branch_i ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
        discard_n = branch_i ? out_n : discard - {1'b0, drop} + {1'b0, granted & stale};
        pc_n      = branch_i ? target : (granted & ~stale) ? pc + 32'd4 : pc;
        issue     = (state == RUN) & (~instr_req_o | granted) & (({1'b0, count_n} + {1'b0, out_n}) < 3'd2);
    end

    // control FSM with registered request; a pending request holds its address until granted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= BOOT;
            instr_req_o  <= 1'b0;
            instr_addr_o <= '0;
            pc           <= BOOT_ADDR;
            stale        <= 1'b0;
            outstanding  <= '0;
            discard      <= '0;
        end else begin
            state        <= fetch_en_i ? RUN : HALT;
            instr_req_o  <= (instr_req_o & ~instr_gnt_i) | issue;
            instr_addr_o <= issue ? pc_n : instr_addr_o;
            pc           <= pc_n;
            stale        <= branch_i ? (instr_req_o & ~instr_gnt_i) : (stale & ~granted);
            outstanding  <= out_n;
            discard      <= discard_n;
        end
    end

    // response FIFO; rsp_pc tracks the address of the next response that will be kept
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count         <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            rsp_pc        <= BOOT_ADDR;
            fifo_pc[0]    <= '0;
            fifo_pc[1]    <= '0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
        end else begin
            count  <= count_n;
            rd_ptr <= branch_i ? wr_ptr : rd_ptr ^ pop;
            rsp_pc <= branch_i ? target : push ? rsp_pc + 32'd4 : rsp_pc;
            if (push) begin
                fifo_pc[wr_ptr]    <= rsp_pc;
                fifo_instr[wr_ptr] <= instr_rdata_i;
                wr_ptr             <= ~wr_ptr;
            end
        end
    end

    assign instr_valid_o = count != 2'd0;
    assign instr_o       = fifo_instr[rd_ptr];
    assign pc_o          = fifo_pc[rd_ptr];
    assign opcode_o      = instr_o[6:0];
    assign funct3_o      = instr_o[14:12];
    assign funct7_o      = instr_o[31:25];
endmodule
